// File: rtl/main_control_unit_if.sv
// Opcode-in / registered-control-word-out bundle of the main control decoder.
interface main_control_unit_if;
  logic [6:0] i_OPCode;
  logic       o_Branch;
  logic       o_MemRead;
  logic       o_MemWrite;
  logic       o_MemToReg;
  logic [1:0] o_ALUOp;
  logic       o_ALUSrc;
  logic       o_RegWrite;
  logic       o_Illegal;

  modport master (
    output i_OPCode,
    input  o_Branch, o_MemRead, o_MemWrite, o_MemToReg,
    input  o_ALUOp, o_ALUSrc, o_RegWrite, o_Illegal
  );

  modport slave (
    input  i_OPCode,
    output o_Branch, o_MemRead, o_MemWrite, o_MemToReg,
    output o_ALUOp, o_ALUSrc, o_RegWrite, o_Illegal
  );
endinterface

// File: rtl/main_control_unit.sv
// RV32I main control decoder: full 7-bit opcode match, control word registered
// at the decode/execute boundary, unsupported opcodes flagged illegal.
module main_control_unit (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  main_control_unit_if.slave   bus
);

  typedef enum logic [6:0] {
    OP_R_TYPE = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Anything that is not an exact match (including X/Z) falls to the default arm.
  always_comb begin
    ctrl_d = '0;
    case (bus.i_OPCode)
      OP_R_TYPE: begin
        ctrl_d.alu_op    = 2'b10;
        ctrl_d.reg_write = 1'b1;
      end
      OP_I_ALU: begin
        ctrl_d.alu_op    = 2'b11;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = 2'b01;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) ctrl_q <= '0;
    else         ctrl_q <= ctrl_d;
  end

  assign bus.o_Branch   = ctrl_q.branch;
  assign bus.o_MemRead  = ctrl_q.mem_read;
  assign bus.o_MemWrite = ctrl_q.mem_write;
  assign bus.o_MemToReg = ctrl_q.mem_to_reg;
  assign bus.o_ALUOp    = ctrl_q.alu_op;
  assign bus.o_ALUSrc   = ctrl_q.alu_src;
  assign bus.o_RegWrite = ctrl_q.reg_write;
  assign bus.o_Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_main_control_unit.sv
// Self-checking bench for main_control_unit: directed cases, exhaustive sweep
// and random opcodes against a table-lookup reference model.
module tb_main_control_unit;

  logic i_CLK;
  logic i_RSTn;
  main_control_unit_if bus ();

  main_control_unit dut (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .bus    (bus.slave)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Observed word: Branch, MemRead, MemWrite, MemToReg, ALUOp[1:0], ALUSrc, RegWrite, Illegal
  logic [8:0] got;
  assign got = {bus.o_Branch, bus.o_MemRead, bus.o_MemWrite, bus.o_MemToReg,
                bus.o_ALUOp, bus.o_ALUSrc, bus.o_RegWrite, bus.o_Illegal};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: the decode list as a lookup table.
  logic [6:0] legal_op [5];
  logic [8:0] legal_word [5];
  initial begin
    legal_op[0] = 7'b0110011; legal_word[0] = 9'b0_0_0_0_10_0_1_0;
    legal_op[1] = 7'b0010011; legal_word[1] = 9'b0_0_0_0_11_1_1_0;
    legal_op[2] = 7'b0000011; legal_word[2] = 9'b0_1_0_1_00_1_1_0;
    legal_op[3] = 7'b0100011; legal_word[3] = 9'b0_0_1_0_00_1_0_0;
    legal_op[4] = 7'b1100011; legal_word[4] = 9'b1_0_0_0_01_0_0_0;
  end

  function automatic logic [8:0] ref_word(input logic [6:0] op);
    for (int i = 0; i < 5; i++)
      if (legal_op[i] == op) return legal_word[i];
    return 9'b0_0_0_0_00_0_0_1;
  endfunction

  task automatic check_invariants(input string tag);
    check({tag, "_rd_wr"},  32'(bus.o_MemRead & bus.o_MemWrite), 32'd0);
    check({tag, "_rw_wr"},  32'(bus.o_RegWrite & (bus.o_MemWrite | bus.o_Branch)), 32'd0);
    check({tag, "_m2r"},    32'(bus.o_MemToReg & ~bus.o_MemRead), 32'd0);
  endtask

  task automatic drive(input logic [6:0] op);
    @(negedge i_CLK);
    bus.i_OPCode = op;
  endtask

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  logic [6:0] ill_ops [5];
  logic [6:0] op;
  int unsigned legal_seen;

  initial begin
    ill_ops[0] = 7'b0110111; ill_ops[1] = 7'b1101111; ill_ops[2] = 7'b0000000;
    ill_ops[3] = 7'b1111111; ill_ops[4] = 7'b0110010;

    i_RSTn = 1'b0;
    bus.i_OPCode = 7'b0110011;
    #1;
    check("reset_init", 32'(got), 32'd0);
    repeat (2) @(posedge i_CLK);
    #1;
    check("reset_hold", 32'(got), 32'd0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    step();
    check("rtype_after_rst", 32'(got), 32'(ref_word(7'b0110011)));

    // Asynchronous reset mid-cycle with an R-type word registered.
    #2;
    i_RSTn = 1'b0;
    #1;
    check("reset_async", 32'(got), 32'd0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    step();
    check("rtype_release", 32'(got), 32'(ref_word(7'b0110011)));
    check("rtype_regwrite", 32'(bus.o_RegWrite), 32'd1);
    check("rtype_aluop", 32'(bus.o_ALUOp), 32'd2);

    for (int i = 0; i < 5; i++) begin
      drive(legal_op[i]);
      step();
      check($sformatf("legal_%0d", i), 32'(got), 32'(ref_word(legal_op[i])));
      check_invariants("legal");
    end

    for (int i = 0; i < 5; i++) begin
      drive(ill_ops[i]);
      step();
      check($sformatf("illegal_%0d", i), 32'(got), 32'(9'b0_0_0_0_00_0_0_1));
    end

    // Opcode change between edges must not reach the outputs early.
    drive(7'b0000011);
    step();
    check("lat_load", 32'(got), 32'(ref_word(7'b0000011)));
    #2;
    bus.i_OPCode = 7'b0100011;
    #1;
    check("lat_hold", 32'(got), 32'(ref_word(7'b0000011)));
    step();
    check("lat_store", 32'(got), 32'(ref_word(7'b0100011)));

    legal_seen = 0;
    for (int i = 0; i < 128; i++) begin
      drive(7'(i));
      step();
      check($sformatf("exh_%0d", i), 32'(got), 32'(ref_word(7'(i))));
      check_invariants("exh");
      if (!bus.o_Illegal) legal_seen++;
    end
    check("legal_count", legal_seen, 32'd5);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) op = legal_op[$urandom_range(0, 4)];
      else                           op = 7'($urandom);
      drive(op);
      step();
      check("rand", 32'(got), 32'(ref_word(op)));
      check_invariants("rand");
      if ($urandom_range(0, 19) == 0) begin
        #1;
        i_RSTn = 1'b0;
        #1;
        check("rand_reset", 32'(got), 32'd0);
        @(negedge i_CLK);
        i_RSTn = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
